// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM answering byte-masked reads/writes after a programmable latency
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   request, we_re         transaction request; 1 = write, 0 = read
//   mask                   byte-lane enables for writes (bit i -> bits [8i+7:8i])
//   address                byte address; bits [ADDR_WIDTH+1:2] select the word
//   store_data             lane-aligned write data
//   valid                  one-cycle completion pulse
//   load_data              read word, held until the next read response or reset
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic h_we;
  logic [3:0] h_mask;
  logic [ADDR_WIDTH-1:0] h_idx;
  logic [31:0] h_data;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx, rd_idx;
  logic accept, go_resp, rd_we;
  logic unused;
  assign unused = ^{address[31:ADDR_WIDTH+2], address[1:0]};
  assign idx = address[ADDR_WIDTH+1:2];
  // valid and load_data are registered, so the read is taken on the edge that
  // enters RESP; with zero latency that edge is the accept edge itself, so the
  // live inputs are used instead of the holding registers.
  always_comb begin
    accept = state == IDLE && request;
    go_resp = (accept && LATENCY == 0) || (state == WAIT && cnt == 4'd0);
    rd_idx = state == IDLE ? idx : h_idx;
    rd_we = state == IDLE ? we_re : h_we;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      valid <= 1'b0;
      load_data <= 32'd0;
    end else begin
      valid <= go_resp;
      if (go_resp && !rd_we) load_data <= mem[rd_idx];
      state <= go_resp ? RESP : accept ? WAIT : state == RESP ? IDLE : state;
      if (accept) cnt <= LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (accept) begin
        h_we <= we_re;
        h_mask <= mask;
        h_idx <= idx;
        h_data <= store_data;
      end
    end
  end
  // Writes commit on the edge that ends RESP, so a reset sampled during RESP
  // still aborts them.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && h_we)
      for (int i = 0; i < 4; i++)
        if (h_mask[i]) mem[h_idx][8*i +: 8] <= h_data[8*i +: 8];
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed check of data_mem_responder at LATENCY 0, 1 and 3
module tb_data_mem_responder;
  localparam int LATS [3] = '{0, 1, 3};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [3];
  logic request [3];
  logic we_re [3];
  logic [3:0] mask [3];
  logic [31:0] address [3];
  logic [31:0] store_data [3];
  logic valid [3];
  logic [31:0] load_data [3];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LATS[g])) dut (
      .clk(clk), .rst(rst[g]), .request(request[g]), .we_re(we_re[g]), .mask(mask[g]),
      .address(address[g]), .store_data(store_data[g]), .valid(valid[g]), .load_data(load_data[g])
    );
  end
  logic [31:0] ref_mem [3][1024];
  logic [31:0] ref_ld [3];
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(input int k, input logic we, input logic [31:0] addr, input logic [3:0] m, input logic [31:0] d);
    logic [9:0] w;
    w = addr[11:2];
    if (we) begin
      for (int i = 0; i < 4; i++) if (m[i]) ref_mem[k][w][8*i +: 8] = d[8*i +: 8];
    end else ref_ld[k] = ref_mem[k][w];
  endtask
  task automatic wait_valid(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid[k] && n < 40);
  endtask
  task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [3:0] m, input logic [31:0] d, input bit scramble);
    int n;
    @(negedge clk);
    request[k] = 1'b1; we_re[k] = we; mask[k] = m; address[k] = addr; store_data[k] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      request[k] = 1'b0;
      if (scramble) begin
        we_re[k] = 1'($urandom); mask[k] = 4'($urandom); address[k] = $urandom; store_data[k] = $urandom;
      end
    end while (!valid[k] && n < 40);
    model(k, we, addr, m, d);
    check($sformatf("latency[%0d]", k), n, LATS[k] + 1);
    check($sformatf("load_data[%0d]@%h", k, addr), load_data[k], ref_ld[k]);
    @(negedge clk);
    check($sformatf("pulse_end[%0d]", k), 32'(valid[k]), 0);
  endtask
  task automatic held(input int k, input logic [31:0] addr);
    int n;
    @(negedge clk);
    request[k] = 1'b1; we_re[k] = 1'b0; mask[k] = 4'hF; address[k] = addr;
    wait_valid(k, n);
    model(k, 1'b0, addr, 4'hF, 0);
    check($sformatf("held_first[%0d]", k), n, LATS[k] + 1);
    wait_valid(k, n);
    request[k] = 1'b0;
    check($sformatf("held_second[%0d]", k), n, LATS[k] + 2);
    check($sformatf("held_data[%0d]", k), load_data[k], ref_ld[k]);
    @(negedge clk);
    check($sformatf("held_end[%0d]", k), 32'(valid[k]), 0);
  endtask
  initial begin
    logic [9:0] pool [8];
    int seen;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; request[k] = 1'b0; we_re[k] = 1'b0; mask[k] = 4'h0;
      address[k] = 0; store_data[k] = 0; ref_ld[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      check($sformatf("rst_valid[%0d]", k), 32'(valid[k]), 0);
      check($sformatf("rst_load[%0d]", k), load_data[k], 0);
    end
    txn(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    txn(1, 1'b0, 32'h10, 4'h0, 0, 1'b0);
    check("plan_deadbeef", load_data[1], 32'hDEADBEEF);
    txn(1, 1'b1, 32'h11, 4'b0010, 32'h0000_5500, 1'b0);
    txn(1, 1'b0, 32'h10, 4'h0, 0, 1'b0);
    check("plan_byte", load_data[1], 32'hDEAD55EF);
    txn(1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0);
    txn(1, 1'b0, 32'h2, 4'h5, 0, 1'b0);
    check("plan_wrap", load_data[1], 32'hCAFEF00D);
    for (int k = 0; k < 3; k++) begin
      txn(k, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5, 1'b0);
      txn(k, 1'b1, 32'h30, 4'h0, 32'h11223344, 1'b1);
      txn(k, 1'b0, 32'h30, 4'hF, 0, 1'b1);
      check($sformatf("mask0[%0d]", k), load_data[k], 32'hA5A5A5A5);
      txn(k, 1'b1, 32'h34, 4'hF, 32'h600D_0000 + k, 1'b0);
      held(k, 32'h34);
    end
    txn(2, 1'b1, 32'h20, 4'hF, 0, 1'b0);
    @(negedge clk);
    request[2] = 1'b1; we_re[2] = 1'b1; mask[2] = 4'hF; address[2] = 32'h20; store_data[2] = 32'h12345678;
    @(negedge clk);
    request[2] = 1'b0; rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    ref_ld[2] = 0;
    check("abort_valid", 32'(valid[2]), 0);
    check("abort_load", load_data[2], 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(valid[2]);
    end
    check("abort_no_pulse", seen, 0);
    txn(2, 1'b0, 32'h20, 4'hF, 0, 1'b0);
    check("abort_mem", load_data[2], 0);
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 8; p++) begin
        pool[p] = 10'(64 + p * 37 + k);
        txn(k, 1'b1, {20'($urandom), pool[p], 2'b00}, 4'hF, $urandom, 1'b0);
      end
      for (int t = 0; t < 30; t++) begin
        txn(k, 1'($urandom), ($urandom & 32'hFFFF_F003) | {20'd0, pool[$urandom_range(7)], 2'b00},
            4'($urandom), $urandom, 1'($urandom));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
